// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Parameterised up/down counter over the range 0..MAX_VAL. It supports
//   synchronous clear and load, a count enable, and either wrap or saturate
//   behaviour at the range limits. The tc and wrapped outputs let several
//   instances be cascaded, for example to build multi-digit BCD counters.
//
// Parameters
//   WIDTH     counter width in bits (>= 1)
//   MAX_VAL   top of the count range (1 .. 2**WIDTH-1)
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
//   RESET_VAL value forced while rst is high (0 .. MAX_VAL)
//
// Ports
//   clk       in   clock; all state changes on posedge
//   rst       in   asynchronous reset, active high
//   en        in   count enable
//   up        in   direction: 1 = increment, 0 = decrement
//   clr       in   synchronous clear to 0 (highest priority)
//   load      in   synchronous load of load_val, clamped to MAX_VAL
//   load_val  in   [WIDTH-1:0] load data
//   out       out  [WIDTH-1:0] registered count
//   tc        out  terminal count, combinational (cascade enable)
//   wrapped   out  registered one-cycle pulse after a wrap
//   sat       out  combinational; high when the count sits at a limit in saturate mode
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrapped,
  output logic             sat
);

  // Parameter legality is checked during elaboration.
  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL out of range");
  end
  if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_rst
    $error("param_updown_counter: RESET_VAL out of range");
  end

  // Comparisons and arithmetic are done at WIDTH+1 bits. This avoids
  // overflow when MAX_VAL is 2**WIDTH-1.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W = MAX_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrapped;
  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_at_lim;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_cnt_x        = {1'b0, r_cnt};
  assign w_inc          = w_cnt_x + 1'b1;
  assign w_dec          = w_cnt_x - 1'b1;
  assign w_at_max       = (w_cnt_x == MAX_X);
  assign w_at_zero      = (r_cnt == '0);
  assign w_at_lim       = up ? w_at_max : w_at_zero;
  assign w_load_clamped = ({1'b0, load_val} > MAX_X) ? MAX_W : load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= RST_W;
      r_wrapped <= 1'b0;
    end else if (clr) begin
      r_cnt     <= '0;
      r_wrapped <= 1'b0;
    end else if (load) begin
      r_cnt     <= w_load_clamped;
      r_wrapped <= 1'b0;
    end else if (en) begin
      if (!w_at_lim) begin
        r_cnt     <= up ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
        r_wrapped <= 1'b0;
      end else if (SATURATE) begin
        r_wrapped <= 1'b0;                 // hold at the limit
      end else begin
        r_cnt     <= up ? '0 : MAX_W;      // wrap to the opposite limit
        r_wrapped <= 1'b1;
      end
    end else begin
      r_wrapped <= 1'b0;
    end
  end

  assign out     = r_cnt;
  assign wrapped = r_wrapped;
  assign tc      = en & w_at_lim;
  assign sat     = SATURATE & w_at_lim;

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;
  localparam int PERIOD = 100;

  logic       clk = 1'b0;
  logic       rst, en, up, clr, load;
  logic [3:0] load_val;
  logic [3:0] out_a, out_s;
  logic       tc_a, tc_s, wr_a, wr_s, sat_a, sat_s;

  int n_vec = 0;
  int n_err = 0;

  always #(PERIOD/2) clk = ~clk;

  // Main instance: MAX_VAL = 9, wrap mode.
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out_a), .tc(tc_a), .wrapped(wr_a), .sat(sat_a)
  );

  // Second instance: MAX_VAL = 15, saturate mode, driven by the same inputs.
  param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b1), .RESET_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out_s), .tc(tc_s), .wrapped(wr_s), .sat(sat_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge. Outputs are then sampled 10 time units after it.
  task automatic tick();
    @(posedge clk);
    #10;
  endtask

  initial begin
    int exp_seq3[4];
    int exp_wr3[4];
    int exp_s4[4];
    int e;
    exp_seq3 = '{1, 0, 9, 8};
    exp_wr3  = '{0, 0, 1, 0};
    exp_s4   = '{14, 15, 15, 15};

    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #50;
    chk("reset_out", out_a, 0);
    chk("reset_wrapped", wr_a, 0);
    tick();
    rst = 1'b0;

    // 1. Async reset in the middle of a count.
    en = 1'b1; up = 1'b1;
    repeat (5) tick();
    chk("t1_count5", out_a, 5);
    #10 rst = 1'b1;                       // posedge + 20
    #1;
    chk("t1_async_out", out_a, 0);
    chk("t1_async_wr", wr_a, 0);
    #20 rst = 1'b0;
    tick();
    chk("t1_resume", out_a, 1);

    // 2. Up count wrapping from 9 to 0.
    en = 1'b0; clr = 1'b1;
    tick();
    chk("t2_clr", out_a, 0);
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = i % 10;
      chk($sformatf("t2_out%0d", i), out_a, e);
      chk($sformatf("t2_tc%0d", i), tc_a, (e == 9) ? 1 : 0);
      chk($sformatf("t2_wr%0d", i), wr_a, (i == 10) ? 1 : 0);
      chk($sformatf("t2_sat%0d", i), sat_a, 0);
    end

    // 3. Down count wrapping from 0 to 9.
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    chk("t3_load", out_a, 2);
    load = 1'b0; up = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_out%0d", i), out_a, exp_seq3[i]);
      chk($sformatf("t3_wr%0d", i), wr_a, exp_wr3[i]);
      if (i == 1) chk("t3_tc_at0", tc_a, 1);
    end

    // 4. Saturate instance with MAX_VAL = 15.
    en = 1'b0; load = 1'b1; load_val = 4'd13; up = 1'b1;
    tick();
    chk("t4_load13", out_s, 13);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_up%0d", i), out_s, exp_s4[i]);
      chk($sformatf("t4_sat%0d", i), sat_s, (exp_s4[i] == 15) ? 1 : 0);
      chk($sformatf("t4_wr%0d", i), wr_s, 0);
    end
    en = 1'b0; load = 1'b1; load_val = 4'd1; up = 1'b0;
    tick();
    chk("t4_load1", out_s, 1);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("t4_dn%0d", i), out_s, 0);
      chk($sformatf("t4_dnsat%0d", i), sat_s, 1);
      chk($sformatf("t4_dnwr%0d", i), wr_s, 0);
    end

    // 5. Priority order: clr, then load, then en.
    up = 1'b1; clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd7;
    tick();
    chk("t5_clr_wins", out_a, 0);
    clr = 1'b0; load_val = 4'd12;
    tick();
    chk("t5_load_clamp", out_a, 9);
    chk("t5_load_sat_inst", out_s, 12);
    chk("t5_wr", wr_a, 0);

    // 6. Hold while en is low.
    en = 1'b0; load = 1'b1; load_val = 4'd4;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t6_hold%0d", i), out_a, 4);
      chk($sformatf("t6_tc%0d", i), tc_a, 0);
      chk($sformatf("t6_wr%0d", i), wr_a, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
